// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler: FSM state encoding,
// channel select codes and reset terminal counts.
package tick_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic SEL_MOD  = 1'b0;
  localparam logic SEL_CTRL = 1'b1;

  localparam int DEF_CNT_W    = 18;
  localparam int DEF_PER_MOD  = 131071;
  localparam int DEF_PER_CTRL = 262143;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: period register, free-running counter with terminal
// compare, and a registered single-cycle tick strobe.
module tick_channel #(
  parameter int CNT_W   = 18,
  parameter int PER_DEF = 131071
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick,
  output logic             at_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_per;
  logic             r_tick;

  assign at_tc = (r_cnt == r_per);
  assign tick  = r_tick;

  // Period register; a load on a terminal-count edge takes effect from the next period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_per <= CNT_W'(PER_DEF);
    end else if (load) begin
      r_per <= load_val;
    end else begin
      r_per <= r_per;
    end
  end

  // Counter and tick; dropping run clears both so a restart begins a full period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_tick <= 1'b0;
    end else if (!run) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_tick <= 1'b0;
    end else if (at_tc) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1'b1);
      r_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Programmable two-channel clock-enable scheduler: run/config FSM, shadow
// register and config handshake around two tick_channel instances.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int PER_MOD_DEF  = DEF_PER_MOD,
  parameter int PER_CTRL_DEF = DEF_PER_CTRL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_period,
  output logic             cfg_ready,
  output logic             tick_mod,
  output logic             tick_ctrl,
  output logic             busy
);

  state_t           r_state;
  logic [CNT_W-1:0] r_shadow;
  logic             r_shadow_sel;
  logic             r_busy;

  logic             w_accept;
  logic             w_run;
  logic             w_tc_mod;
  logic             w_tc_ctrl;
  logic             w_sel_tc;
  logic             w_apply;
  logic             w_apply_sel;
  logic [CNT_W-1:0] w_apply_val;
  logic             w_load_mod;
  logic             w_load_ctrl;

  assign cfg_ready   = (r_state != PEND);
  assign busy        = r_busy;
  assign w_accept    = cfg_valid && cfg_ready;
  assign w_run       = en && (r_state != IDLE);
  assign w_sel_tc    = (r_shadow_sel == SEL_CTRL) ? w_tc_ctrl : w_tc_mod;
  assign w_load_mod  = w_apply && (w_apply_sel == SEL_MOD);
  assign w_load_ctrl = w_apply && (w_apply_sel == SEL_CTRL);

  // Decide whether a period register is written this edge, and from where.
  always_comb begin
    w_apply     = 1'b0;
    w_apply_sel = r_shadow_sel;
    w_apply_val = r_shadow;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_apply     = 1'b1;
          w_apply_sel = cfg_sel;
          w_apply_val = cfg_period;
        end else begin
          w_apply     = 1'b0;
        end
      end
      RUN: begin
        if (w_accept && !en) begin
          w_apply     = 1'b1;
          w_apply_sel = cfg_sel;
          w_apply_val = cfg_period;
        end else begin
          w_apply     = 1'b0;
        end
      end
      PEND: begin
        if (!en || w_sel_tc) begin
          w_apply = 1'b1;
        end else begin
          w_apply = 1'b0;
        end
      end
      default: begin
        w_apply = 1'b0;
      end
    endcase
  end

  // Run/config FSM with shadow capture and registered busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_shadow     <= {CNT_W{1'b0}};
      r_shadow_sel <= SEL_MOD;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= en ? RUN : IDLE;
        end
        RUN: begin
          if (!en) begin
            r_state <= IDLE;
          end else if (w_accept) begin
            r_shadow     <= cfg_period;
            r_shadow_sel <= cfg_sel;
            r_busy       <= 1'b1;
            r_state      <= PEND;
          end else begin
            r_state <= RUN;
          end
        end
        PEND: begin
          if (!en || w_sel_tc) begin
            r_busy  <= 1'b0;
            r_state <= en ? RUN : IDLE;
          end else begin
            r_state <= PEND;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  tick_channel #(
    .CNT_W   (CNT_W),
    .PER_DEF (PER_MOD_DEF)
  ) u_mod (
    .clk      (clk),
    .rst      (rst),
    .run      (w_run),
    .load     (w_load_mod),
    .load_val (w_apply_val),
    .tick     (tick_mod),
    .at_tc    (w_tc_mod)
  );

  tick_channel #(
    .CNT_W   (CNT_W),
    .PER_DEF (PER_CTRL_DEF)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .run      (w_run),
    .load     (w_load_ctrl),
    .load_val (w_apply_val),
    .tick     (tick_ctrl),
    .at_tc    (w_tc_ctrl)
  );

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a timestamp-based model.
module tb_tick_scheduler;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         cfg_valid;
  logic         cfg_sel;
  logic [W-1:0] cfg_period;
  logic         cfg_ready;
  logic         tick_mod;
  logic         tick_ctrl;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Model: a channel ticks when per+1 run edges have elapsed since its period start.
  int k = 0;
  bit m_run;
  bit m_pend;
  int m_per[2];
  int m_anchor[2];
  bit m_tick[2];
  int m_sh;
  bit m_sh_sel;

  tick_scheduler #(
    .CNT_W        (W),
    .PER_MOD_DEF  (3),
    .PER_CTRL_DEF (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_sel    (cfg_sel),
    .cfg_period (cfg_period),
    .cfg_ready  (cfg_ready),
    .tick_mod   (tick_mod),
    .tick_ctrl  (tick_ctrl),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, k);
    end
  endtask

  task automatic model_reset();
    m_run     = 1'b0;
    m_pend    = 1'b0;
    m_per[0]  = 3;
    m_per[1]  = 7;
    m_tick[0] = 1'b0;
    m_tick[1] = 1'b0;
    m_sh      = 0;
    m_sh_sel  = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    k++;
    acc = cfg_valid && !m_pend;
    for (int x = 0; x < 2; x++) begin
      m_tick[x] = 1'b0;
      if (m_run && en && (k - m_anchor[x] == m_per[x] + 1)) begin
        m_tick[x]   = 1'b1;
        m_anchor[x] = k;
      end
    end
    if (!m_run) begin
      if (acc) m_per[cfg_sel] = int'(cfg_period);
      if (en) begin
        m_run       = 1'b1;
        m_anchor[0] = k;
        m_anchor[1] = k;
      end
    end else if (!m_pend) begin
      if (!en) begin
        m_run = 1'b0;
        if (acc) m_per[cfg_sel] = int'(cfg_period);
      end else if (acc) begin
        m_pend   = 1'b1;
        m_sh     = int'(cfg_period);
        m_sh_sel = cfg_sel;
      end
    end else begin
      if (!en) begin
        m_per[m_sh_sel] = m_sh;
        m_pend = 1'b0;
        m_run  = 1'b0;
      end else if (m_tick[m_sh_sel]) begin
        m_per[m_sh_sel] = m_sh;
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("tick_mod", tick_mod, m_tick[0]);
      chk("tick_ctrl", tick_ctrl, m_tick[1]);
      chk("busy", busy, m_pend);
      chk("cfg_ready", cfg_ready, !m_pend);
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_period = 4'd0;
    model_reset();
    #2;
    chk("reset_ready", cfg_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ticks", {tick_mod, tick_ctrl}, 0);
    chk_on = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Default periods 3/7, mod reprogrammed to 1 at cycle 5.
    en = 1'b1;
    tick_cycle();
    for (int c = 1; c <= 16; c++) begin
      if (c == 5) begin cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_period = 4'd1; end
      tick_cycle();
      cfg_valid = 1'b0;
      chk("d1_tick_mod", tick_mod, (c == 4 || c == 8 || (c > 8 && c % 2 == 0)));
      chk("d1_tick_ctrl", tick_ctrl, (c % 8 == 0));
      chk("d1_busy", busy, (c >= 5 && c <= 7));
    end
    en = 1'b0;
    tick_cycle();
    chk("d1_stop", {tick_mod, tick_ctrl}, 0);

    // Config in IDLE writes directly: ctrl period 3.
    cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_period = 4'd2;
    tick_cycle();
    cfg_valid = 1'b0;
    chk("d2_idle_busy", busy, 0);
    en = 1'b1;
    tick_cycle();
    for (int c = 1; c <= 9; c++) begin
      tick_cycle();
      chk("d2_tick_ctrl", tick_ctrl, (c % 3 == 0));
      chk("d2_tick_mod", tick_mod, (c % 2 == 0));
      chk("d2_busy", busy, 0);
    end

    // Period 1 on mod: continuous ticks, cleared on the edge after en falls.
    en = 1'b0;
    tick_cycle();
    cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_period = 4'd0;
    tick_cycle();
    cfg_valid = 1'b0;
    en = 1'b1;
    tick_cycle();
    for (int c = 1; c <= 5; c++) begin
      tick_cycle();
      chk("d3_tick_mod_cont", tick_mod, 1);
    end
    en = 1'b0;
    tick_cycle();
    chk("d3_tick_mod_off", tick_mod, 0);

    // Drop en while pending: shadow applied on the way to IDLE.
    en = 1'b1;
    tick_cycle();
    cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_period = 4'd5;
    tick_cycle();
    cfg_valid = 1'b0;
    chk("d4_pend_busy", busy, 1);
    chk("d4_pend_ready", cfg_ready, 0);
    en = 1'b0;
    tick_cycle();
    chk("d4_drop_busy", busy, 0);
    chk("d4_drop_ready", cfg_ready, 1);
    en = 1'b1;
    tick_cycle();
    for (int c = 1; c <= 12; c++) begin
      tick_cycle();
      chk("d4_tick_ctrl", tick_ctrl, (c % 6 == 0));
    end

    // Asynchronous reset mid-pending discards the config and restores 3/7.
    do_reset();
    tick_cycle();
    cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_period = 4'd2;
    tick_cycle();
    cfg_valid = 1'b0;
    repeat (4) tick_cycle();
    chk("d5_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("d5_async_busy", busy, 0);
    chk("d5_async_ready", cfg_ready, 1);
    chk("d5_async_ticks", {tick_mod, tick_ctrl}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick_cycle();
    for (int c = 1; c <= 8; c++) begin
      tick_cycle();
      chk("d5_tick_mod", tick_mod, (c % 4 == 0));
      chk("d5_tick_ctrl", tick_ctrl, (c == 8));
    end

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      en         = ($urandom_range(0, 15) != 0);
      cfg_valid  = ($urandom_range(0, 5) == 0);
      cfg_sel    = 1'($urandom_range(0, 1));
      cfg_period = ($urandom_range(0, 7) == 0) ? 4'd15 : W'($urandom_range(0, 9));
      tick_cycle();
    end
    cfg_valid = 1'b0;
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
